// File: rtl/popcount_scheduler.sv
// Round-robin scheduler sharing one iterative popcount engine between N_REQ requesters.
// Issues each job as a one-cycle load pulse and returns the count tagged with its requester ID.
module popcount_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned ID_W   = $clog2(N_REQ),
  localparam int unsigned RES_W  = $clog2(DATA_W) + 2
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_val_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]         pc_data_o,
  output logic                      pc_data_val_o,
  input  logic [RES_W-1:0]          pc_res_i,
  input  logic                      pc_res_val_i,
  output logic [RES_W-1:0]          res_data_o,
  output logic [ID_W-1:0]           res_id_o,
  output logic                      res_err_o,
  output logic                      res_val_o,
  input  logic                      res_ready_i,
  output logic                      busy_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_err_q, res_err_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [DATA_W-1:0] grant_word;

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_word  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned     k;
      logic [ID_W-1:0] kk;
      k  = (32'(ptr_q) + i) % N_REQ;
      kk = ID_W'(k);
      if (!grant_found && req_val_i[kk]) begin
        grant_found = 1'b1;
        grant_idx   = kk;
        grant_word  = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && grant_found && !srst_i) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    res_err_d  = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d = S_ISSUE;
          ptr_d   = ID_W'((32'(grant_idx) + 1) % N_REQ);
          id_d    = grant_idx;
          data_d  = grant_word;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q == 0 marks the first WAIT cycle, where engine pulses are not trusted.
        if (pc_res_val_i && cnt_q != '0) begin
          state_d    = S_OUT;
          res_data_d = pc_res_i;
          res_id_d   = id_q;
          res_err_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = S_OUT;
          res_data_d = '0;
          res_id_d   = id_q;
          res_err_d  = 1'b1;
        end
      end
      default: begin
        if (res_ready_i) begin
          state_d    = S_IDLE;
          res_data_d = '0;
          res_id_d   = '0;
          res_err_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      res_err_q  <= res_err_d;
    end
  end

  assign pc_data_o     = data_q;
  assign pc_data_val_o = (state_q == S_ISSUE);
  assign res_data_o    = res_data_q;
  assign res_id_o      = res_id_q;
  assign res_err_o     = res_err_q;
  assign res_val_o     = (state_q == S_OUT);
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_popcount_scheduler.sv
// Directed bench for popcount_scheduler with a behavioural engine (result at load+2+popcount cycles).
module tb_popcount_scheduler;

  logic        clk = 1'b0;
  logic        srst;
  logic [63:0] req_data;
  logic [3:0]  req_val;
  logic [3:0]  req_ready;
  logic [15:0] pc_data;
  logic        pc_data_val;
  logic [5:0]  pc_res;
  logic        pc_res_val;
  logic [5:0]  res_data;
  logic [1:0]  res_id;
  logic        res_err;
  logic        res_val;
  logic        res_ready;
  logic        busy;

  logic        eng_en;
  logic        spur;
  logic [5:0]  spur_val;
  logic        eng_busy;
  int unsigned eng_left;
  logic [5:0]  eng_res;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  popcount_scheduler #(.N_REQ(4), .DATA_W(16), .TIMEOUT(20)) dut (
    .clk_i(clk), .srst_i(srst), .req_data_i(req_data), .req_val_i(req_val),
    .req_ready_o(req_ready), .pc_data_o(pc_data), .pc_data_val_o(pc_data_val),
    .pc_res_i(pc_res), .pc_res_val_i(pc_res_val), .res_data_o(res_data),
    .res_id_o(res_id), .res_err_o(res_err), .res_val_o(res_val),
    .res_ready_i(res_ready), .busy_o(busy)
  );

  // Engine model: result pulse in the (popcount+1)-th cycle after the load cycle ends.
  always @(posedge clk or posedge srst) begin
    if (srst) begin
      eng_busy <= 1'b0;
      eng_left <= 0;
      eng_res  <= '0;
    end else if (eng_en && pc_data_val) begin
      eng_busy <= 1'b1;
      eng_left <= $countones(pc_data) + 1;
      eng_res  <= 6'($countones(pc_data));
    end else if (eng_busy) begin
      if (eng_left == 0) eng_busy <= 1'b0;
      else eng_left <= eng_left - 1;
    end
  end

  assign pc_res_val = (eng_busy && eng_left == 0) || spur;
  assign pc_res     = (eng_busy && eng_left == 0) ? eng_res : spur_val;

  typedef struct {
    int          id;
    logic [15:0] word;
    int          exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int start, output int lat);
    bit found;
    found = 1'b0;
    lat   = start;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (res_val) begin
        found = 1'b1;
        break;
      end
    end
    chk("res_seen", found, 1);
  endtask

  task automatic run_single(input int id, input logic [15:0] w, input int exp_res,
                            input int exp_lat, input bit exp_err);
    int lat;
    req_data[id*16 +: 16] = w;
    req_val   = 4'(1 << id);
    res_ready = 1'b1;
    #1;
    chk("grant", req_ready, 1 << id);
    chk("busy_idle", busy, 0);
    tick();
    req_val = '0;
    chk("load_pulse", pc_data_val, 1);
    chk("load_word", pc_data, w);
    chk("ready_issue", req_ready, 0);
    wait_out(1, lat);
    chk("latency", lat, exp_lat);
    chk("res_data", res_data, exp_res);
    chk("res_id", res_id, id);
    chk("res_err", res_err, exp_err);
    tick();
    chk("val_drop", res_val, 0);
    chk("data_clr", res_data, 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic rr_job(input int exp_id, input int exp_res);
    int lat;
    #1;
    chk("rr_grant", req_ready, 1 << exp_id);
    tick();
    wait_out(1, lat);
    chk("rr_id", res_id, exp_id);
    chk("rr_res", res_data, exp_res);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    vecs[0] = '{id: 2, word: 16'hF0F0, exp_res: 8,  exp_lat: 12};
    vecs[1] = '{id: 0, word: 16'h0000, exp_res: 0,  exp_lat: 4};
    vecs[2] = '{id: 1, word: 16'h1234, exp_res: 5,  exp_lat: 9};
    vecs[3] = '{id: 0, word: 16'h8001, exp_res: 2,  exp_lat: 6};
    vecs[4] = '{id: 3, word: 16'hFFFF, exp_res: 16, exp_lat: 20};

    srst = 1'b1; req_data = 64'h1234_5678_9ABC_DEF0; req_val = 4'hF;
    res_ready = 1'b0; eng_en = 1'b1; spur = 1'b0; spur_val = '0;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_val", res_val, 0);
    chk("rst_pcdata", pc_data, 0);
    chk("rst_pcval", pc_data_val, 0);
    @(negedge clk);
    srst = 1'b0; req_val = '0; req_data = '0;
    tick();

    for (int i = 0; i < 5; i++)
      run_single(vecs[i].id, vecs[i].word, vecs[i].exp_res, vecs[i].exp_lat, 1'b0);

    // Round robin starting from pointer 0.
    req_data = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    req_val = 4'hF; res_ready = 1'b1;
    rr_job(0, 1); rr_job(1, 2); rr_job(2, 3); rr_job(3, 4); rr_job(0, 1);
    req_val = 4'b1010;
    rr_job(1, 2); rr_job(3, 4); rr_job(1, 2);
    req_val = '0;

    // Spurious engine pulses in IDLE, ISSUE and the first WAIT cycle.
    spur = 1'b1; spur_val = 6'd7;
    #1;
    chk("spur_idle_val", res_val, 0);
    tick();
    chk("spur_idle_val2", res_val, 0);
    chk("spur_idle_busy", busy, 0);
    spur = 1'b0;
    req_data[15:0] = 16'h0003; req_val = 4'b0001;
    #1;
    chk("spur_grant", req_ready, 1);
    tick();
    req_val = '0; spur = 1'b1; spur_val = 6'd9;
    tick();
    #1;
    chk("spur_wait1", res_val, 0);
    tick();
    spur = 1'b0;
    wait_out(3, lat);
    chk("spur_lat", lat, 6);
    chk("spur_res", res_data, 2);
    chk("spur_id", res_id, 0);
    tick();

    // Backpressure with req0 and req2 pending; pointer is 1 so req2 wins.
    req_data[15:0] = 16'h000F; req_data[47:32] = 16'h00FF;
    req_val = 4'b0101; res_ready = 1'b0;
    #1;
    chk("bp_grant", req_ready, 4'b0100);
    tick();
    wait_out(1, lat);
    chk("bp_res", res_data, 8);
    chk("bp_id", res_id, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_val_hold", res_val, 1);
      chk("bp_data_hold", res_data, 8);
      chk("bp_id_hold", res_id, 2);
      chk("bp_ready_hold", req_ready, 0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_ready_release", req_ready, 0);
    tick();
    chk("bp_next_grant", req_ready, 4'b0001);
    chk("bp_val_drop", res_val, 0);
    tick();
    req_val = '0;
    wait_out(1, lat);
    chk("bp2_res", res_data, 4);
    chk("bp2_id", res_id, 0);
    tick();

    // Timeout with a silent engine, then a late pulse at WAIT cycle 25.
    eng_en = 1'b0;
    run_single(1, 16'h0F00, 0, 22, 1'b1);
    tick(); tick(); tick();
    spur = 1'b1; spur_val = 6'd5;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (res_val) cnt++;
      tick();
      spur = 1'b0;
    end
    chk("late_pulse_vals", cnt, 0);
    chk("late_pulse_busy", busy, 0);
    eng_en = 1'b1;

    // Asynchronous reset mid-WAIT; the pointer would otherwise favour req3.
    req_data[31:16] = 16'hFFFF; req_val = 4'b0010;
    #1;
    chk("ar_grant", req_ready, 4'b0010);
    tick();
    req_val = '0;
    tick(); tick(); tick();
    chk("ar_in_wait", busy, 1);
    req_val = 4'b1001;
    #2;
    srst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_val", res_val, 0);
    chk("ar_ready", req_ready, 0);
    chk("ar_pcdata", pc_data, 0);
    chk("ar_resdata", res_data, 0);
    chk("ar_resid", res_id, 0);
    @(negedge clk);
    srst = 1'b0;
    #1;
    chk("ar_ptr0_grant", req_ready, 4'b0001);
    tick();
    req_val = '0;
    chk("ar_load", pc_data_val, 1);
    chk("ar_word", pc_data, 16'h000F);
    wait_out(1, lat);
    chk("ar_lat", lat, 8);
    chk("ar_res", res_data, 4);
    chk("ar_id", res_id, 0);
    chk("ar_err", res_err, 0);
    tick();
    chk("ar_done", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
